// File: rtl/aliens_bus_initiator.sv
// ---------------------------------------------------------------------------
// aliens_bus_initiator
//
// Purpose: takes single-beat read/write requests on a valid/ready port and
// replays each one as a timed 052526-style external bus cycle (address setup,
// WAIT-stretchable strobe, one hold cycle), then reports completion with a
// one-cycle rsp_valid pulse. It also owns the BK4/WOCO/INIT decoder control
// bits, which only ever change on entry to IDLE (or in IDLE) so they are
// stable whenever AS may be low.
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_addr, req_we, req_wdata request address, direction, write data
//   rsp_valid, rsp_rdata, rsp_err  completion pulse, read data, timeout flag
//   ctl_we, ctl_wdata          control register write, {INIT, WOCO, BK4}
//   ADDR, AS, RW, DOUT, DOE    external bus address/strobe/direction/data
//   DIN, WAIT                  external bus read data and strobe stretch
//   BK4, WOCO, INIT            decoder control bits
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module aliens_bus_initiator #(
  parameter int ASU_CYC  = 2,
  parameter int AS_CYC   = 4,
  parameter int WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  input  logic        req_we,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  input  logic        ctl_we,
  input  logic [2:0]  ctl_wdata,
  output logic [15:0] ADDR,
  output logic        AS,
  output logic        RW,
  output logic [7:0]  DOUT,
  output logic        DOE,
  input  logic [7:0]  DIN,
  input  logic        WAIT,
  output logic        BK4,
  output logic        WOCO,
  output logic        INIT
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [15:0] addr_q, addr_d;
  logic        as_q, as_d;
  logic        rw_q, rw_d;
  logic [7:0]  dout_q, dout_d;
  logic        doe_q, doe_d;
  logic [2:0]  ctl_q, ctl_d;
  logic        pend_q, pend_d;
  logic [2:0]  pend_val_q, pend_val_d;

  // Next-state logic. cnt_q is shared: it counts setup cycles in SETUP and
  // WAIT-low strobe cycles in STROBE; wcnt_q counts WAIT-high strobe cycles
  // for the timeout. The registered strobe/ready/valid outputs are derived
  // from state_d so they line up exactly with the state they describe.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wcnt_d      = wcnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    dout_d      = dout_q;
    doe_d       = doe_q;
    ctl_d       = ctl_q;
    pend_d      = pend_q;
    pend_val_d  = pend_val_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d    = req_addr;
          rw_d      = ~req_we;
          dout_d    = req_wdata;
          doe_d     = req_we;
          rsp_err_d = 1'b0;
          cnt_d     = 4'd0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == 4'(ASU_CYC - 1)) begin
          cnt_d   = 4'd0;
          wcnt_d  = 8'd0;
          state_d = STROBE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      STROBE: begin
        // A WAIT-high cycle only feeds the timeout counter; the strobe phase
        // advances solely on WAIT-low cycles.
        if (WAIT) begin
          if (wcnt_q == 8'(WAIT_MAX - 1)) begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 8'hFF;
            state_d     = HOLD;
          end else begin
            wcnt_d = wcnt_q + 8'd1;
          end
        end else if (cnt_q == 4'(AS_CYC - 1)) begin
          if (rw_q) begin
            rsp_rdata_d = DIN;
          end
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HOLD: begin
        state_d = IDLE;
        doe_d   = 1'b0;
        rw_d    = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Control bits may only move on an edge that lands in IDLE. From HOLD the
    // next state is always IDLE, so a write seen there (or a parked one) is
    // applied directly; elsewhere it is parked, newest value winning.
    if (ctl_we) begin
      if (state_q == IDLE || state_q == HOLD) begin
        ctl_d  = ctl_wdata;
        pend_d = 1'b0;
      end else begin
        pend_d     = 1'b1;
        pend_val_d = ctl_wdata;
      end
    end else if (state_q == HOLD && pend_q) begin
      ctl_d  = pend_val_q;
      pend_d = 1'b0;
    end

    as_d        = (state_d != STROBE);
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == HOLD);
  end

  // State and output registers; reset returns everything to idle values and
  // discards any parked control write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      wcnt_q      <= 8'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_err_q   <= 1'b0;
      addr_q      <= 16'h0000;
      as_q        <= 1'b1;
      rw_q        <= 1'b1;
      dout_q      <= 8'h00;
      doe_q       <= 1'b0;
      ctl_q       <= 3'b000;
      pend_q      <= 1'b0;
      pend_val_q  <= 3'b000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wcnt_q      <= wcnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      addr_q      <= addr_d;
      as_q        <= as_d;
      rw_q        <= rw_d;
      dout_q      <= dout_d;
      doe_q       <= doe_d;
      ctl_q       <= ctl_d;
      pend_q      <= pend_d;
      pend_val_q  <= pend_val_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign ADDR      = addr_q;
  assign AS        = as_q;
  assign RW        = rw_q;
  assign DOUT      = dout_q;
  assign DOE       = doe_q;
  assign BK4       = ctl_q[0];
  assign WOCO      = ctl_q[1];
  assign INIT      = ctl_q[2];

endmodule

// File: tb/tb_aliens_bus_initiator.sv
// ---------------------------------------------------------------------------
// tb_aliens_bus_initiator
//
// Directed bench for aliens_bus_initiator (WAIT_MAX overridden to 8 so the
// timeout case stays short). Each transaction is accepted at edge T; the
// bench then logs every output once per cycle at the falling edge, where
// log index k holds cycle T+k, and compares against hand-derived values.
// ---------------------------------------------------------------------------
module tb_aliens_bus_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic        req_we;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        ctl_we;
  logic [2:0]  ctl_wdata;
  logic [15:0] ADDR;
  logic        AS;
  logic        RW;
  logic [7:0]  DOUT;
  logic        DOE;
  logic [7:0]  DIN;
  logic        WAIT;
  logic        BK4;
  logic        WOCO;
  logic        INIT;

  int testsRun    = 0;
  int testsFailed = 0;

  // Per-cycle logs: bit/entry k-1 (vectors) or k (arrays) is cycle T+k.
  logic [31:0] asVec, validVec, readyVec, doeVec, rwVec;
  logic [15:0] addrLog  [1:32];
  logic [7:0]  rdataLog [1:32];
  logic [7:0]  doutLog  [1:32];
  logic        errLog   [1:32];
  logic [2:0]  ctlLog   [1:32];

  aliens_bus_initiator #(
    .ASU_CYC (2),
    .AS_CYC  (4),
    .WAIT_MAX(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_we   (req_we),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .ctl_we   (ctl_we),
    .ctl_wdata(ctl_wdata),
    .ADDR     (ADDR),
    .AS       (AS),
    .RW       (RW),
    .DOUT     (DOUT),
    .DOE      (DOE),
    .DIN      (DIN),
    .WAIT     (WAIT),
    .BK4      (BK4),
    .WOCO     (WOCO),
    .INIT     (INIT)
  );

  // Free-running 100 MHz-style clock.
  always #5 clk = ~clk;

  // Hard stop in case something never returns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Presents one request and returns #1 after the accepting edge T.
  task automatic applyStimulus(input logic [15:0] addr, input logic we,
                               input logic [7:0] wdata);
    logic accepted;
    accepted  = 1'b0;
    req_addr  = addr;
    req_we    = we;
    req_wdata = wdata;
    req_valid = 1'b1;
    for (int i = 0; i < 40 && !accepted; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        accepted = 1'b1;
      end
    end
    req_valid = 1'b0;
    if (!accepted) checkOutput("request handshake timeout", 64'd0, 64'd1);
  endtask

  // Runs n cycles after acceptance, driving WAIT/DIN/reset/ctl per cycle and
  // logging the outputs of each cycle at its falling edge.
  task automatic runCycles(input int n, input logic [31:0] waitMask,
                           input logic seqDin, input int resetAt,
                           input int ctlAt1, input logic [2:0] ctlVal1,
                           input int ctlAt2, input logic [2:0] ctlVal2);
    asVec = '0; validVec = '0; readyVec = '0; doeVec = '0; rwVec = '0;
    for (int k = 1; k <= n; k++) begin
      WAIT      = waitMask[k-1];
      if (seqDin) DIN = 8'h10 + 8'(k);
      reset     = (k == resetAt);
      ctl_we    = (k == ctlAt1) || (k == ctlAt2);
      ctl_wdata = (k == ctlAt2) ? ctlVal2 : ctlVal1;
      @(negedge clk);
      asVec[k-1]    = AS;
      validVec[k-1] = rsp_valid;
      readyVec[k-1] = req_ready;
      doeVec[k-1]   = DOE;
      rwVec[k-1]    = RW;
      addrLog[k]    = ADDR;
      rdataLog[k]   = rsp_rdata;
      doutLog[k]    = DOUT;
      errLog[k]     = rsp_err;
      ctlLog[k]     = {INIT, WOCO, BK4};
      @(posedge clk);
      #1;
    end
    WAIT   = 1'b0;
    reset  = 1'b0;
    ctl_we = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = 16'h0000;
    req_we    = 1'b0;
    req_wdata = 8'h00;
    ctl_we    = 1'b0;
    ctl_wdata = 3'b000;
    DIN       = 8'h00;
    WAIT      = 1'b0;

    // Reset values.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset handshake/rsp", {req_ready, rsp_valid, rsp_err, rsp_rdata},
                {1'b1, 1'b0, 1'b0, 8'h00});
    checkOutput("reset bus", {ADDR, AS, RW, DOUT, DOE}, {16'h0000, 1'b1, 1'b1, 8'h00, 1'b0});
    checkOutput("reset ctl bits", {INIT, WOCO, BK4}, 3'b000);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Plain read: AS low T+3..T+6, rsp_valid at T+7, ready again at T+8.
    DIN = 8'h5A;
    applyStimulus(16'h4000, 1'b0, 8'h00);
    runCycles(8, 32'h0, 1'b0, 0, 0, 3'b000, 0, 3'b000);
    checkOutput("read AS timeline", asVec[7:0], 8'b1100_0011);
    checkOutput("read rsp_valid timeline", validVec[7:0], 8'b0100_0000);
    checkOutput("read req_ready timeline", readyVec[7:0], 8'b1000_0000);
    checkOutput("read RW high", rwVec[7:0], 8'hFF);
    checkOutput("read DOE low", doeVec[7:0], 8'h00);
    checkOutput("read ADDR", addrLog[1], 16'h4000);
    checkOutput("read rsp_rdata", rdataLog[7], 8'h5A);
    checkOutput("read rsp_err", errLog[7], 1'b0);

    // Write: DOE=1, RW=0, DOUT held T+1..T+7; read data untouched.
    applyStimulus(16'h0100, 1'b1, 8'hA5);
    runCycles(8, 32'h0, 1'b0, 0, 0, 3'b000, 0, 3'b000);
    checkOutput("write DOE timeline", doeVec[7:0], 8'b0111_1111);
    checkOutput("write RW timeline", rwVec[7:0], 8'b1000_0000);
    checkOutput("write AS timeline", asVec[7:0], 8'b1100_0011);
    checkOutput("write rsp_valid timeline", validVec[7:0], 8'b0100_0000);
    checkOutput("write DOUT first/last", {doutLog[1], doutLog[7]}, {8'hA5, 8'hA5});
    checkOutput("write ADDR", addrLog[4], 16'h0100);
    checkOutput("write rdata unchanged", rdataLog[7], 8'h5A);
    checkOutput("write ready at T+8", readyVec[7], 1'b1);

    // Read with WAIT high in T+3..T+5: AS low T+3..T+9, capture DIN of T+9.
    applyStimulus(16'h4001, 1'b0, 8'h00);
    runCycles(11, 32'h0000_001C, 1'b1, 0, 0, 3'b000, 0, 3'b000);
    checkOutput("wait read AS timeline", asVec[10:0], 11'b110_0000_0011);
    checkOutput("wait read rsp_valid timeline", validVec[10:0], 11'b010_0000_0000);
    checkOutput("wait read rsp_rdata", rdataLog[10], 8'h19);
    checkOutput("wait read rsp_err", errLog[10], 1'b0);

    // WAIT stuck high: abort after 8 WAIT cycles, HOLD at T+11.
    applyStimulus(16'h4002, 1'b0, 8'h00);
    runCycles(12, 32'hFFFF_FFFC, 1'b0, 0, 0, 3'b000, 0, 3'b000);
    checkOutput("abort AS timeline", asVec[11:0], 12'hC03);
    checkOutput("abort rsp_valid timeline", validVec[11:0], 12'h400);
    checkOutput("abort rsp_err", errLog[11], 1'b1);
    checkOutput("abort rsp_rdata", rdataLog[11], 8'hFF);

    // Next normal read clears rsp_err at acceptance.
    DIN = 8'h3C;
    applyStimulus(16'h4003, 1'b0, 8'h00);
    runCycles(8, 32'h0, 1'b0, 0, 0, 3'b000, 0, 3'b000);
    checkOutput("post-abort rsp_err cleared", {errLog[1], errLog[7]}, 2'b00);
    checkOutput("post-abort rsp_rdata", rdataLog[7], 8'h3C);

    // Control write during STROBE lands only on the edge entering IDLE.
    applyStimulus(16'h4004, 1'b0, 8'h00);
    runCycles(8, 32'h0, 1'b0, 0, 4, 3'b101, 0, 3'b000);
    checkOutput("ctl held through HOLD", ctlLog[7], 3'b000);
    checkOutput("ctl applied in IDLE", ctlLog[8], 3'b101);

    // Two control writes before IDLE: newest wins.
    applyStimulus(16'h4005, 1'b0, 8'h00);
    runCycles(8, 32'h0, 1'b0, 0, 3, 3'b110, 5, 3'b010);
    checkOutput("ctl old value in HOLD", ctlLog[7], 3'b101);
    checkOutput("ctl newest wins", ctlLog[8], 3'b010);

    // Reset in the second STROBE cycle of a write, with a parked ctl write.
    applyStimulus(16'h2222, 1'b1, 8'h77);
    runCycles(8, 32'h0, 1'b0, 4, 3, 3'b111, 0, 3'b000);
    checkOutput("reset mid-cycle bus", {asVec[4], doeVec[4], addrLog[5]},
                {1'b1, 1'b0, 16'h0000});
    checkOutput("reset mid-cycle ready", readyVec[4], 1'b1);
    checkOutput("reset mid-cycle no rsp_valid", validVec[7:0], 8'h00);
    checkOutput("reset drops pending ctl", ctlLog[8], 3'b000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/aliens_bus_initiator.md
# aliens_bus_initiator

Synchronous bus-cycle initiator for the Aliens I/O mapper: it accepts single-beat read and write requests on a valid/ready port and replays them as timed 052526-style external bus cycles. It drives address, strobe and data toward the address-decode PALs, and stretches the strobe with a wait input. It also owns the BK4, WOCO and INIT control bits that the decoders consume, so a simulation or FPGA host can exercise every decoded select.

## Interface
- ASU_CYC, 2: address-setup cycles with AS high before the strobe (1..15).
- AS_CYC, 4: minimum AS-low cycles (1..15).
- WAIT_MAX, 255: number of WAIT-extended cycles before the cycle is aborted (1..255).
- clk  in  1  single system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_addr  in  16  bus address.
- req_we  in  1  1 = write, 0 = read.
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  8  read data; valid with rsp_valid.
- rsp_err  out  1  wait timeout; valid with rsp_valid.
- ctl_we  in  1  control register write.
- ctl_wdata  in  3  {INIT, WOCO, BK4}.
- ADDR  out  16  bus address.
- AS  out  1  address strobe, active-low.
- RW  out  1  1 = read, 0 = write.
- DOUT  out  8  write data.
- DOE  out  1  data output enable.
- DIN  in  8  read data from the bus.
- WAIT  in  1  active-high strobe stretch.
- BK4, WOCO, INIT  out  1 each  decoder control bits.

## Operation
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=8'h00, rsp_err=0, ADDR=16'h0000, AS=1, RW=1, DOUT=8'h00, DOE=0, BK4=0, WOCO=0, INIT=0, pending-control flag clear, FSM in IDLE.
- FSM states are IDLE, SETUP, STROBE and HOLD.
- IDLE
  - req_ready=1.
  - On handshake, register ADDR=req_addr, RW=~req_we, DOUT=req_wdata and DOE=req_we, then go to SETUP.
- SETUP
  - AS=1 for ASU_CYC cycles, then go to STROBE.
- STROBE
  - AS=0.
  - The phase counter advances only in cycles where WAIT=0, so the strobe lasts AS_CYC cycles in which WAIT=0.
  - A separate wait counter counts the cycles where WAIT=1.
  - On the final WAIT=0 cycle of a read, capture DIN into rsp_rdata at that edge, then go to HOLD.
  - If the wait counter reaches WAIT_MAX, abort: rsp_err=1 and rsp_rdata=8'hFF (reads and writes), then go to HOLD.
- HOLD
  - Exactly 1 cycle with AS=1; ADDR, RW, DOUT and DOE are held.
  - rsp_valid=1 in this cycle for every request, read or write, including aborted ones.
  - Next state is IDLE; DOE=0 and RW=1 on entering IDLE.
  - ADDR keeps its last value while in IDLE.
- rsp_err is cleared at the next accepted request.
- rsp_rdata is unchanged by a write that completes normally.
- Control bits
  - A ctl_we in IDLE updates {INIT, WOCO, BK4} at that edge.
  - A ctl_we outside IDLE is stored as pending and applied on the edge that enters IDLE, so the bits never change while AS may be low.
  - If a second ctl_we arrives before that point, the newest value wins.
  - A ctl_we and req_valid in the same IDLE cycle are both taken: the cycle starts with the new control bits.
- Reset asserted in any state: everything returns to its reset value at that edge. There is no rsp_valid and any pending control write is discarded.

## Timing
- A request accepted at edge T produces:
  - SETUP in cycles T+1..T+ASU_CYC.
  - AS low in cycles T+ASU_CYC+1..T+ASU_CYC+AS_CYC+w, where w is the number of WAIT-high cycles.
  - HOLD and rsp_valid in cycle T+ASU_CYC+AS_CYC+w+1.
- req_ready is high only in IDLE, so the minimum request-to-request spacing is ASU_CYC+AS_CYC+2 cycles.
- WAIT is sampled every STROBE cycle. A WAIT=1 cycle extends AS low by one cycle without advancing the phase counter. WAIT is ignored outside STROBE.
- DIN is sampled only on the read-capture edge; no other cycle affects rsp_rdata.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Read, defaults, DIN=8'h5A, WAIT=0, addr 16'h4000 accepted at T -> AS=0 exactly in cycles T+3..T+6, RW=1, DOE=0 throughout, rsp_valid in T+7 with rsp_rdata=8'h5A and rsp_err=0.
- Write 8'hA5 to 16'h0100 -> DOE=1, RW=0, DOUT=8'hA5 from T+1 through T+7; AS low for 4 cycles; rsp_valid at T+7; rsp_rdata unchanged; next request accepted at T+8.
- Read with WAIT=1 for 3 cycles starting at the first STROBE cycle -> AS low for 7 cycles, rsp_valid at T+10, data captured on the last strobe edge.
- WAIT_MAX=8 with WAIT held at 1 -> after 8 WAIT cycles AS returns high, rsp_valid=1, rsp_err=1, rsp_rdata=8'hFF; the next normal request clears rsp_err.
- ctl_we=3'b101 during STROBE -> BK4 and INIT stay 0 until the edge that enters IDLE, then BK4=1, WOCO=0, INIT=1. Back-to-back ctl_we=3'b010 before IDLE -> final state WOCO=1 only.
- Reset pulse in the second STROBE cycle -> AS=1, DOE=0, ADDR=16'h0000 and req_ready=1 on the next cycle, with no rsp_valid and the pending control write dropped.
